// File: rtl/vga_pkg.sv
// Raster timing constants and coordinate type shared by the timing generator
// and the ball/paddle draw blocks.
package vga_pkg;

  typedef logic [11:0] coord_t;

  localparam int unsigned COORD_LIMIT = 4096;

  // 800x600@72 Hz from a 50 MHz pixel clock
  localparam int unsigned DEF_H_VISIBLE = 800;
  localparam int unsigned DEF_H_FPORCH  = 56;
  localparam int unsigned DEF_H_SYNC    = 120;
  localparam int unsigned DEF_H_BPORCH  = 64;
  localparam int unsigned DEF_V_VISIBLE = 600;
  localparam int unsigned DEF_V_FPORCH  = 37;
  localparam int unsigned DEF_V_SYNC    = 6;
  localparam int unsigned DEF_V_BPORCH  = 23;

  function automatic int unsigned h_total(input int unsigned vis, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned vis, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

  // True for lo <= c < lo+len.
  function automatic logic in_window(input coord_t c, input int unsigned lo,
                                     input int unsigned len);
    return (32'(c) >= lo) && (32'(c) < lo + len);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with enable; wrap flags the enabled cycle at N-1 and
// count_next exposes the value the register takes on the next edge.
module mod_counter
  import vga_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t count,
  output coord_t count_next,
  output logic   wrap
);

  localparam coord_t LAST = coord_t'(N - 1);

  coord_t count_q;
  coord_t count_d;
  logic   at_last;

  always_comb begin
    at_last = (count_q == LAST);
    count_d = count_q;
    if (rst) begin
      count_d = '0;
    end else if (en) begin
      count_d = at_last ? '0 : coord_t'(count_q + 12'd1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count      = count_q;
  assign count_next = count_d;
  assign wrap       = en & ~rst & at_last;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, registered sync/blanking outputs
// and one-pixel line/frame-end strobes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FPORCH  = DEF_H_FPORCH,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BPORCH  = DEF_H_BPORCH,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FPORCH  = DEF_V_FPORCH,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BPORCH  = DEF_V_BPORCH,
  parameter bit          H_POL     = 1'b1,
  parameter bit          V_POL     = 1'b1
) (
  input  logic   PixelClock,
  input  logic   Reset,
  input  logic   PixelEn,
  output coord_t xPos,
  output coord_t yPos,
  output logic   hSync,
  output logic   vSync,
  output logic   videoOn,
  output logic   lineEnd,
  output logic   frameEnd
);

  localparam int unsigned H_TOTAL  = h_total(H_VISIBLE, H_FPORCH, H_SYNC, H_BPORCH);
  localparam int unsigned V_TOTAL  = v_total(V_VISIBLE, V_FPORCH, V_SYNC, V_BPORCH);
  localparam int unsigned HS_START = H_VISIBLE + H_FPORCH;
  localparam int unsigned VS_START = V_VISIBLE + V_FPORCH;

  generate
    if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_range_check
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 12-bit coordinate range");
    end
  endgenerate

  coord_t x_count, x_next, y_count, y_next;
  logic   x_wrap, y_wrap;

  mod_counter #(.N(H_TOTAL)) u_x_cnt (
    .clk       (PixelClock),
    .rst       (Reset),
    .en        (PixelEn),
    .count     (x_count),
    .count_next(x_next),
    .wrap      (x_wrap)
  );

  // x_wrap already carries PixelEn and !Reset, so y steps once per enabled line end.
  mod_counter #(.N(V_TOTAL)) u_y_cnt (
    .clk       (PixelClock),
    .rst       (Reset),
    .en        (x_wrap),
    .count     (y_count),
    .count_next(y_next),
    .wrap      (y_wrap)
  );

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic video_on_q, video_on_d;

  // Decoding the next-state coordinates keeps the registered outputs aligned
  // with xPos/yPos in the same cycle.
  always_comb begin
    hsync_d    = in_window(x_next, HS_START, H_SYNC) ? H_POL : ~H_POL;
    vsync_d    = in_window(y_next, VS_START, V_SYNC) ? V_POL : ~V_POL;
    video_on_d = (32'(x_next) < H_VISIBLE) && (32'(y_next) < V_VISIBLE);
    if (Reset) begin
      hsync_d    = ~H_POL;
      vsync_d    = ~V_POL;
      video_on_d = 1'b1;
    end
  end

  always_ff @(posedge PixelClock) begin
    hsync_q    <= hsync_d;
    vsync_q    <= vsync_d;
    video_on_q <= video_on_d;
  end

  assign xPos     = x_count;
  assign yPos     = y_count;
  assign hSync    = hsync_q;
  assign vSync    = vsync_q;
  assign videoOn  = video_on_q;
  assign lineEnd  = x_wrap;
  assign frameEnd = y_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 800x600 build plus two small-raster builds
// (active-high and active-low syncs) checked against a reference raster model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        hs;
    logic        vs;
    logic        von;
  } vis_t;

  typedef struct {
    int hv, hf, hsw, hb, vv, vf, vsw, vb;
    bit hpol, vpol;
  } geom_t;

  typedef struct {
    int   idx;
    vis_t exp;
  } sb_t;

  typedef struct {
    logic r, e, le;
    vis_t exp;
  } vec_t;

  logic clk, rst, en;
  logic [11:0] x_d, y_d, x_s, y_s, x_p, y_p;
  logic hs_d, vs_d, von_d, le_d, fe_d;
  logic hs_s, vs_s, von_s, le_s, fe_s;
  logic hs_p, vs_p, von_p, le_p, fe_p;

  int total = 0;
  int bad   = 0;

  geom_t g[3];
  int    mx[3], my[3];
  sb_t   sbq[$];
  bit    model_ok = 0;
  logic  last_le[3], last_fe[3];
  vec_t  tbl[18];

  vga_timing_gen u_dut_d (
    .PixelClock(clk), .Reset(rst), .PixelEn(en), .xPos(x_d), .yPos(y_d),
    .hSync(hs_d), .vSync(vs_d), .videoOn(von_d), .lineEnd(le_d), .frameEnd(fe_d)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FPORCH(2), .H_SYNC(3), .H_BPORCH(3),
    .V_VISIBLE(4), .V_FPORCH(1), .V_SYNC(2), .V_BPORCH(1)
  ) u_dut_s (
    .PixelClock(clk), .Reset(rst), .PixelEn(en), .xPos(x_s), .yPos(y_s),
    .hSync(hs_s), .vSync(vs_s), .videoOn(von_s), .lineEnd(le_s), .frameEnd(fe_s)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FPORCH(2), .H_SYNC(3), .H_BPORCH(3),
    .V_VISIBLE(4), .V_FPORCH(1), .V_SYNC(2), .V_BPORCH(1),
    .H_POL(1'b0), .V_POL(1'b0)
  ) u_dut_p (
    .PixelClock(clk), .Reset(rst), .PixelEn(en), .xPos(x_p), .yPos(y_p),
    .hSync(hs_p), .vSync(vs_p), .videoOn(von_p), .lineEnd(le_p), .frameEnd(fe_p)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vis_t got(input int i);
    case (i)
      0:       return '{x: x_d, y: y_d, hs: hs_d, vs: vs_d, von: von_d};
      1:       return '{x: x_s, y: y_s, hs: hs_s, vs: vs_s, von: von_s};
      default: return '{x: x_p, y: y_p, hs: hs_p, vs: vs_p, von: von_p};
    endcase
  endfunction

  function automatic logic got_le(input int i);
    return (i == 0) ? le_d : (i == 1) ? le_s : le_p;
  endfunction

  function automatic logic got_fe(input int i);
    return (i == 0) ? fe_d : (i == 1) ? fe_s : fe_p;
  endfunction

  function automatic vis_t mkv(input int x, input int y, input logic hs, input logic vs,
                               input logic von);
    vis_t v;
    v.x = 12'(x); v.y = 12'(y); v.hs = hs; v.vs = vs; v.von = von;
    return v;
  endfunction

  function automatic vec_t mk(input logic r, input logic e, input logic le, input int x,
                              input int y, input logic hs, input logic vs, input logic von);
    vec_t t;
    t.r = r; t.e = e; t.le = le; t.exp = mkv(x, y, hs, vs, von);
    return t;
  endfunction

  function automatic vis_t model_vis(input int i);
    int hs0, vs0;
    vis_t v;
    hs0   = g[i].hv + g[i].hf;
    vs0   = g[i].vv + g[i].vf;
    v.x   = 12'(mx[i]);
    v.y   = 12'(my[i]);
    v.hs  = (mx[i] >= hs0 && mx[i] < hs0 + g[i].hsw) ? g[i].hpol : !g[i].hpol;
    v.vs  = (my[i] >= vs0 && my[i] < vs0 + g[i].vsw) ? g[i].vpol : !g[i].vpol;
    v.von = (mx[i] < g[i].hv) && (my[i] < g[i].vv);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_vis(input string nm, input vis_t act, input vis_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b von=%b, want x=%0d y=%0d hs=%b vs=%b von=%b",
               nm, act.x, act.y, act.hs, act.vs, act.von, exp.x, exp.y, exp.hs, exp.vs, exp.von);
    end
  endtask

  // One pixel clock: drive inputs, check strobes before the edge, advance the
  // model and queue its prediction, then compare registered outputs after the edge.
  task automatic step(input logic r, input logic e);
    int ht, vt;
    logic ele, efe;
    sb_t s;
    rst = r;
    en  = e;
    #1;
    for (int i = 0; i < 3; i++) begin
      last_le[i] = got_le(i);
      last_fe[i] = got_fe(i);
      ht  = g[i].hv + g[i].hf + g[i].hsw + g[i].hb;
      vt  = g[i].vv + g[i].vf + g[i].vsw + g[i].vb;
      ele = e && !r && (mx[i] == ht - 1);
      efe = ele && (my[i] == vt - 1);
      if (model_ok) begin
        chk($sformatf("lineEnd[%0d]", i), 32'(got_le(i)), 32'(ele));
        chk($sformatf("frameEnd[%0d]", i), 32'(got_fe(i)), 32'(efe));
      end
      if (r) begin
        mx[i] = 0;
        my[i] = 0;
      end else if (e) begin
        if (mx[i] == ht - 1) begin
          mx[i] = 0;
          my[i] = (my[i] == vt - 1) ? 0 : my[i] + 1;
        end else begin
          mx[i] = mx[i] + 1;
        end
      end
      if (model_ok || r) begin
        s.idx = i;
        s.exp = model_vis(i);
        sbq.push_back(s);
      end
    end
    if (r) model_ok = 1;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      chk_vis($sformatf("raster[%0d]", s.idx), got(s.idx), s.exp);
    end
  endtask

  initial begin : main
    vis_t pv, cv;
    int n, fe_n, fe_at, vs_n, vsl_n;
    int rise_x, fall_x, vfall_x, le_n, le_x, hs_n;
    bit found;

    g[0] = '{800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1};
    g[1] = '{8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1};
    g[2] = '{8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0};

    tbl[0]  = mk(0, 1, 0, 7, 0, 0, 0, 1);
    tbl[1]  = mk(0, 1, 0, 8, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 9, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 10, 0, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 10, 0, 1, 0, 0);
    tbl[5]  = mk(0, 1, 0, 11, 0, 1, 0, 0);
    tbl[6]  = mk(0, 1, 0, 12, 0, 1, 0, 0);
    tbl[7]  = mk(0, 1, 0, 13, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 0, 14, 0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 0, 15, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 15, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 15, 0, 0, 0, 0);
    tbl[12] = mk(0, 1, 1, 0, 1, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 1, 0, 0, 1);
    tbl[14] = mk(0, 1, 0, 1, 1, 0, 0, 1);
    tbl[15] = mk(1, 1, 0, 0, 0, 0, 0, 1);
    tbl[16] = mk(1, 0, 0, 0, 0, 0, 0, 1);
    tbl[17] = mk(0, 1, 0, 1, 0, 0, 0, 1);

    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk);
    #1;

    // Reset held five cycles.
    for (int k = 0; k < 5; k++) begin
      step(1, 1);
      chk_vis("reset_default", got(0), mkv(0, 0, 0, 0, 1));
      chk_vis("reset_small", got(1), mkv(0, 0, 0, 0, 1));
      chk("reset_pol_hs", 32'(hs_p), 1);
      chk("reset_pol_vs", 32'(vs_p), 1);
      chk("reset_le", 32'(last_le[1]), 0);
      chk("reset_fe", 32'(last_fe[1]), 0);
    end

    for (int k = 0; k < 6; k++) step(0, 1);
    chk_vis("approach", got(1), mkv(6, 0, 0, 0, 1));

    // Hand-computed vectors: hsync edges, videoOn fall, PixelEn gaps at the wrap, reset.
    for (int k = 0; k < 18; k++) begin
      step(tbl[k].r, tbl[k].e);
      chk($sformatf("vec%0d_le", k), 32'(last_le[1]), 32'(tbl[k].le));
      chk_vis($sformatf("vec%0d", k), got(1), tbl[k].exp);
    end

    // Small raster: one full frame between frameEnd strobes.
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      step(0, 1);
      found = last_fe[1];
    end
    chk("frame_sync_found", 32'(found), 1);
    fe_n = 0; fe_at = -1; vs_n = 0; vsl_n = 0;
    for (int k = 0; k < 128; k++) begin
      step(0, 1);
      if (last_fe[1]) begin
        fe_n++;
        fe_at = k;
        chk_vis("after_frameEnd", got(1), mkv(0, 0, 0, 0, 1));
      end
      if (hs_s === 1'bx) vs_n = vs_n + 0;
      if (vs_s) vs_n++;
      if (!vs_p) vsl_n++;
    end
    chk("frameEnd_count", fe_n, 1);
    chk("frameEnd_pos", fe_at, 127);
    chk("vsync_cycles", vs_n, 32);
    chk("vsync_low_cycles", vsl_n, 32);

    // Default raster: one full line from reset.
    step(1, 1);
    step(1, 1);
    rise_x = -1; fall_x = -1; vfall_x = -1; le_n = 0; le_x = -1; hs_n = 0;
    for (int k = 0; k < 1040; k++) begin
      pv = got(0);
      step(0, 1);
      cv = got(0);
      if (!pv.hs && cv.hs) rise_x = 32'(cv.x);
      if (pv.hs && !cv.hs) fall_x = 32'(cv.x);
      if (pv.von && !cv.von) vfall_x = 32'(cv.x);
      if (last_le[0]) begin
        le_n++;
        le_x = 32'(pv.x);
      end
      if (cv.hs) hs_n++;
    end
    chk("hsync_rise_x", rise_x, 856);
    chk("hsync_fall_x", fall_x, 976);
    chk("videoOn_fall_x", vfall_x, 800);
    chk("lineEnd_count", le_n, 1);
    chk("lineEnd_x", le_x, 1039);
    chk("hsync_width", hs_n, 120);
    chk_vis("line_wrap", got(0), mkv(0, 1, 0, 0, 1));

    // Reset inside both sync pulses of the small raster.
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      step(0, 1);
      found = (x_s == 12'd11) && (y_s == 12'd5);
    end
    chk("mid_target_found", 32'(found), 1);
    chk("mid_in_sync", 32'({hs_s, vs_s, hs_p, vs_p}), 32'(4'b1100));
    step(1, 1);
    chk_vis("mid_reset", got(1), mkv(0, 0, 0, 0, 1));
    chk("mid_reset_pol", 32'({hs_p, vs_p}), 32'(2'b11));
    n = -1;
    for (int k = 1; k <= 40 && n < 0; k++) begin
      step(0, 1);
      if (hs_s) n = k;
    end
    chk("restart_hsync_delay", n, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
